inst_fetch: RTL

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch unit: walks the PC through a one-outstanding-request
// instruction memory, delivers each fetched word to decode with a one-cycle
// valid pulse, and supports PC redirects, fetch timeouts and a sticky halt.
module inst_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          TIMEOUT_CYC = 15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        fetch_en,
  input  logic        pc_we,
  input  logic [31:0] pc_next,
  input  logic        HALT,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  output logic [31:0] INST,
  output logic        inst_valid,
  output logic [31:0] inst_pc,
  output logic [31:0] PC,
  output logic [31:0] PC_PLUS4,
  output logic        busy,
  output logic        fetch_err,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_HALTED
  } state_t;

  localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  // The counter holds the number of WAIT cycles already spent, so the fetch
  // is abandoned at the end of the TIMEOUT_CYC-th WAIT cycle.
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYC - 1);
  localparam logic [31:0]   NOP_INST  = 32'h0000_0013;

  state_t        r_state;
  logic [31:0]   r_pc;
  logic [31:0]   r_imem_addr;
  logic [31:0]   r_inst;
  logic [31:0]   r_inst_pc;
  logic          r_imem_req;
  logic          r_inst_valid;
  logic          r_fetch_err;
  logic          r_redir;
  logic [CW-1:0] r_wait_cnt;
  logic [31:0]   w_fetch_addr;

  // A same-cycle redirect takes precedence over the current PC for a launch.
  assign w_fetch_addr = pc_we ? pc_next : r_pc;

  // Fetch FSM: state, PC, latched address, fetched word and all pulse outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_imem_addr  <= 32'h0;
      r_inst       <= NOP_INST;
      r_inst_pc    <= 32'h0;
      r_imem_req   <= 1'b0;
      r_inst_valid <= 1'b0;
      r_fetch_err  <= 1'b0;
      r_redir      <= 1'b0;
      r_wait_cnt   <= '0;
    end else begin
      r_imem_req   <= 1'b0;
      r_inst_valid <= 1'b0;
      r_fetch_err  <= 1'b0;
      if (HALT) begin
        r_state <= S_HALTED;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (pc_we) r_pc <= pc_next;
            if (fetch_en) begin
              if (w_fetch_addr[1:0] == 2'b00) begin
                r_state     <= S_REQ;
                r_imem_addr <= w_fetch_addr;
                r_imem_req  <= 1'b1;
                r_redir     <= 1'b0;
              end else begin
                r_fetch_err <= 1'b1;
              end
            end
          end
          S_REQ: begin
            if (pc_we) begin
              r_pc    <= pc_next;
              r_redir <= 1'b1;
            end
            r_wait_cnt <= '0;
            r_state    <= S_WAIT;
          end
          S_WAIT: begin
            if (pc_we) begin
              r_pc    <= pc_next;
              r_redir <= 1'b1;
            end
            if (IMEM_RVALID) begin
              r_inst       <= IMEM_RDATA;
              r_inst_pc    <= r_imem_addr;
              r_inst_valid <= 1'b1;
              r_state      <= S_DONE;
            end else if (r_wait_cnt == LAST_WAIT) begin
              r_fetch_err <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_wait_cnt <= r_wait_cnt + 1'b1;
            end
          end
          S_DONE: begin
            if (pc_we) begin
              r_pc    <= pc_next;
              r_redir <= 1'b1;
            end else if (!r_redir) begin
              r_pc <= r_inst_pc + 32'd4;
            end
            r_state <= S_IDLE;
          end
          S_HALTED: begin
            r_state <= S_HALTED;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign IMEM_REQ   = r_imem_req;
  assign IMEM_ADDR  = r_imem_addr;
  assign INST       = r_inst;
  assign inst_valid = r_inst_valid;
  assign inst_pc    = r_inst_pc;
  assign PC         = r_pc;
  assign PC_PLUS4   = r_inst_pc + 32'd4;
  assign fetch_err  = r_fetch_err;
  assign busy       = (r_state == S_REQ) || (r_state == S_WAIT) || (r_state == S_DONE);
  assign halted     = (r_state == S_HALTED);

endmodule
